// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared agent state and command types for the 4-way round-robin arbiter slice
package arb_pkg;

    localparam int NUM_AGENTS = 4;
    localparam int CMD_ADDR_W = 16;
    localparam int CMD_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } agent_state_e;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_LEN_W-1:0]  len;
    } cmd_t;

endpackage

// File: rtl/arb_cmd_fifo.sv
// rtl/arb_cmd_fifo.sv - synchronous command FIFO with full/empty flags
module arb_cmd_fifo
    import arb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cmd_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Flags come from the registered count, so a pop never makes room for a same-cycle push.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - requester agent for one arbiter port; ARB_AGENT_WDOG_EN enables the grant-wait watchdog
module arb_req_agent
    import arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 16,
    parameter int LEN_W    = 4,
    parameter int WDOG_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              request,
    input  logic              grant,
    output logic              end_transaction,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ready,
    output logic              busy,
    output logic              proto_err,
    output logic              wdog_err
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } agent_cmd_t;

    agent_state_e     state_q, state_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic             proto_err_q, proto_err_d;
    agent_cmd_t       wcmd, head;
    logic             fifo_full, fifo_empty, fifo_pop;

    assign wcmd = '{addr: cmd_addr, len: cmd_len};

    arb_cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (agent_cmd_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (wcmd),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (head)
    );

    // A lost grant leaves the head in place so the same burst is replayed from beat 0.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        proto_err_d = proto_err_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            IDLE: if (!fifo_empty && !grant) state_d = REQ;
            REQ: begin
                if (grant) begin
                    state_d = XFER;
                    beat_d  = '0;
                end
            end
            XFER: begin
                if (!grant) begin
                    state_d     = IDLE;
                    proto_err_d = 1'b1;
                end else if (bus_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == head.len) state_d = DONE;
                end
            end
            DONE: begin
                fifo_pop = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign cmd_ready       = !fifo_full;
    assign request         = (state_q == REQ);
    assign bus_valid       = (state_q == XFER);
    assign end_transaction = (state_q == DONE);
    assign bus_addr        = bus_valid ? (head.addr + ADDR_W'(beat_q)) : '0;
    assign busy            = (state_q != IDLE) || !fifo_empty;
    assign proto_err       = proto_err_q;

`ifdef ARB_AGENT_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;

    always_comb begin
        wdog_cnt_d = '0;
        wdog_err_d = wdog_err_q;
        if (state_q == REQ) begin
            wdog_cnt_d = (wdog_cnt_q == WDOG_W'(WDOG_CYC)) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
            if (wdog_cnt_d == WDOG_W'(WDOG_CYC)) wdog_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = (WDOG_CYC == 0);
    assign wdog_err        = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// tb/tb_arb_req_agent.sv - self-checking bench for arb_req_agent (vector table, directed corners, random vs model)
module tb_arb_req_agent;

    localparam int DEPTH = 4;
`ifdef ARB_AGENT_WDOG_EN
    localparam logic WDOG_EXP = 1'b1;
`else
    localparam logic WDOG_EXP = 1'b0;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        request;
    logic        grant = 1'b0;
    logic        end_transaction;
    logic        bus_valid;
    logic [15:0] bus_addr;
    logic        bus_ready = 1'b0;
    logic        busy;
    logic        proto_err;
    logic        wdog_err;

    always #5 clk = ~clk;

    arb_req_agent #(
        .DEPTH    (DEPTH),
        .ADDR_W   (16),
        .LEN_W    (4),
        .WDOG_CYC (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .request         (request),
        .grant           (grant),
        .end_transaction (end_transaction),
        .bus_valid       (bus_valid),
        .bus_addr        (bus_addr),
        .bus_ready       (bus_ready),
        .busy            (busy),
        .proto_err       (proto_err),
        .wdog_err        (wdog_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; grant = 1'b0; bus_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [3:0] l);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_request(input string nm);
        int t = 0;
        while (request !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        chk({nm, "_request"}, request, 1);
    endtask

    // Acts as the arbiter for one burst: grant, accept every beat, drop grant after end_transaction.
    task automatic serve(input logic [15:0] a, input logic [3:0] l, input string nm);
        logic [15:0] ea;
        wait_request(nm);
        grant = 1'b1; bus_ready = 1'b1;
        step();
        for (int b = 0; b <= int'(l); b++) begin
            ea = a + 16'(b);
            chk({nm, "_bus_valid"}, bus_valid, 1);
            chk({nm, "_bus_addr"}, bus_addr, ea);
            step();
        end
        chk({nm, "_eot"}, end_transaction, 1);
        grant = 1'b0; bus_ready = 1'b0;
        step();
        chk({nm, "_eot_one_cycle"}, end_transaction, 0);
        chk({nm, "_gap"}, request, 0);
    endtask

    typedef struct {
        logic        cv;
        logic [15:0] a;
        logic [3:0]  l;
        logic        g;
        logic        br;
        logic        cr;
        logic        rq;
        logic        bv;
        logic [15:0] ba;
        logic        eot;
        logic        bsy;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  len;
    } mcmd_t;

    vec_t  tv [12];
    mcmd_t q  [$];

    initial begin
        // single burst addr 0x10 len 3, grant four cycles into the request
        tv[0]  = '{H, 16'h0010, 4'd3, L, H,  H, L, L, 16'h0000, L, H};
        tv[1]  = '{L, 16'h0000, 4'd0, L, H,  H, H, L, 16'h0000, L, H};
        tv[2]  = '{L, 16'h0000, 4'd0, L, H,  H, H, L, 16'h0000, L, H};
        tv[3]  = '{L, 16'h0000, 4'd0, L, H,  H, H, L, 16'h0000, L, H};
        tv[4]  = '{L, 16'h0000, 4'd0, L, H,  H, H, L, 16'h0000, L, H};
        tv[5]  = '{L, 16'h0000, 4'd0, H, H,  H, L, H, 16'h0010, L, H};
        tv[6]  = '{L, 16'h0000, 4'd0, H, H,  H, L, H, 16'h0011, L, H};
        tv[7]  = '{L, 16'h0000, 4'd0, H, H,  H, L, H, 16'h0012, L, H};
        tv[8]  = '{L, 16'h0000, 4'd0, H, H,  H, L, H, 16'h0013, L, H};
        tv[9]  = '{L, 16'h0000, 4'd0, H, H,  H, L, L, 16'h0000, H, H};
        tv[10] = '{L, 16'h0000, 4'd0, H, H,  H, L, L, 16'h0000, L, L};
        tv[11] = '{L, 16'h0000, 4'd0, L, L,  H, L, L, 16'h0000, L, L};

        do_reset();
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_request", request, 0);
        chk("reset_bus_valid", bus_valid, 0);
        chk("reset_bus_addr", bus_addr, 0);
        chk("reset_eot", end_transaction, 0);
        chk("reset_busy", busy, 0);
        chk("reset_proto_err", proto_err, 0);
        chk("reset_wdog_err", wdog_err, 0);

        for (int i = 0; i < 12; i++) begin
            cmd_valid = tv[i].cv; cmd_addr = tv[i].a; cmd_len = tv[i].l;
            grant = tv[i].g; bus_ready = tv[i].br;
            step();
            chk($sformatf("t1_row%0d_cmd_ready", i), cmd_ready, tv[i].cr);
            chk($sformatf("t1_row%0d_request", i), request, tv[i].rq);
            chk($sformatf("t1_row%0d_bus_valid", i), bus_valid, tv[i].bv);
            chk($sformatf("t1_row%0d_bus_addr", i), bus_addr, tv[i].ba);
            chk($sformatf("t1_row%0d_eot", i), end_transaction, tv[i].eot);
            chk($sformatf("t1_row%0d_busy", i), busy, tv[i].bsy);
        end

        // fill past capacity with no grant; the fifth command must be dropped
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            chk($sformatf("t2_cmd_ready_%0d", i), cmd_ready, (i < DEPTH));
            push(16'((i + 1) * 16'h0100), 4'(i));
        end
        chk("t2_full_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < DEPTH; i++) begin
            serve(16'((i + 1) * 16'h0100), 4'(i), $sformatf("t2_burst%0d", i));
        end
        step(); step(); step();
        chk("t2_no_fifth_request", request, 0);
        chk("t2_busy_done", busy, 0);

        // address wrap
        do_reset();
        push(16'hFFFE, 4'd3);
        serve(16'hFFFE, 4'd3, "t3_wrap");

        // grant lost after the second beat, same-cycle bus_ready must not count
        do_reset();
        push(16'h0040, 4'd3);
        wait_request("t4");
        grant = 1'b1; bus_ready = 1'b1;
        step();
        chk("t4_beat0", bus_addr, 16'h0040);
        step();
        chk("t4_beat1", bus_addr, 16'h0041);
        step();
        chk("t4_beat2", bus_addr, 16'h0042);
        grant = 1'b0;
        step();
        chk("t4_proto_err", proto_err, 1);
        chk("t4_no_eot", end_transaction, 0);
        chk("t4_bus_valid_off", bus_valid, 0);
        chk("t4_busy_retained", busy, 1);
        bus_ready = 1'b0;
        serve(16'h0040, 4'd3, "t4_replay");
        chk("t4_proto_err_sticky", proto_err, 1);

        // reset in the middle of a burst
        do_reset();
        push(16'h0030, 4'd3);
        push(16'h0050, 4'd1);
        wait_request("t5");
        grant = 1'b1; bus_ready = 1'b1;
        step();
        step();
        chk("t5_in_xfer", bus_addr, 16'h0031);
        rst = 1'b1;
        step();
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_request", request, 0);
        chk("t5_bus_valid", bus_valid, 0);
        chk("t5_bus_addr", bus_addr, 0);
        chk("t5_eot", end_transaction, 0);
        chk("t5_busy", busy, 0);
        chk("t5_proto_err", proto_err, 0);
        rst = 1'b0; grant = 1'b0; bus_ready = 1'b0;
        step(); step(); step();
        chk("t5_fifo_empty_request", request, 0);
        chk("t5_fifo_empty_busy", busy, 0);

        // grant withheld well past the watchdog limit
        do_reset();
        push(16'h0077, 4'd0);
        wait_request("t6");
        for (int i = 0; i < 30; i++) step();
        chk("t6_wdog_early", wdog_err, 0);
        for (int i = 0; i < 40; i++) step();
        chk("t6_wdog_err", wdog_err, WDOG_EXP);
        chk("t6_request_held", request, 1);
        serve(16'h0077, 4'd0, "t6_after");
        chk("t6_wdog_sticky", wdog_err, WDOG_EXP);

        // random traffic against a transaction-level model
        do_reset();
        begin
            int    beat_idx = 0;
            int    gwait = 0;
            logic  eot_exp = 1'b0;
            logic  eot_next;
            logic  prev_eot = 1'b0;
            logic  acc_push;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                chk("rnd_cmd_ready", cmd_ready, (q.size() < DEPTH));
                chk("rnd_eot", end_transaction, eot_exp);
                if (prev_eot) chk("rnd_gap", request, 0);
                if (bus_valid) begin
                    chk("rnd_beat_has_cmd", (q.size() > 0), 1);
                    if (q.size() > 0) chk("rnd_bus_addr", bus_addr, q[0].addr + 16'(beat_idx));
                end

                cmd_valid = (cyc < 1500) && ($urandom_range(0, 2) == 0);
                cmd_addr  = 16'($urandom);
                cmd_len   = 4'($urandom_range(0, 15));
                bus_ready = ($urandom_range(0, 3) != 0);
                if (end_transaction) begin
                    grant = 1'b0;
                end else if (request && !grant) begin
                    if (gwait == 0) begin
                        grant = 1'b1;
                        gwait = $urandom_range(0, 3);
                    end else begin
                        gwait--;
                    end
                end

                acc_push = cmd_valid && (q.size() < DEPTH);
                eot_next = 1'b0;
                if (bus_valid && bus_ready && q.size() > 0) begin
                    if (beat_idx == int'(q[0].len)) begin
                        eot_next = 1'b1;
                        beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end
                if (eot_exp && q.size() > 0) void'(q.pop_front());
                if (acc_push) q.push_back('{cmd_addr, cmd_len});
                prev_eot = end_transaction;
                eot_exp  = eot_next;
                step();
            end
            chk("rnd_drained", q.size(), 0);
            chk("rnd_busy_end", busy, 0);
            chk("rnd_proto_err", proto_err, 0);
            chk("rnd_wdog_err", wdog_err, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
